// File: rtl/ppu_row_sched.sv
// ppu_row_sched -- schedules per-scanline row renders and VRAM bank flips.
//
// Ports:
//   video_clk        sole clock, rising edge
//   rst_n            asynchronous active-low reset
//   enable           level, 1 = scheduling permitted
//   vblank_start     pulse, start of vertical blank (forces VBLANK)
//   vblank_end_soon  pulse, two scanlines before first visible line
//   rowram_swap      pulse, video output swapped row buffers (row deadline)
//   render_done      pulse, renderer finished the current row
//   cpu_swap_req     level, CPU requests a VRAM bank flip
//   render_start     pulse, renderer must build render_row
//   render_row[7:0]  row index 0..239, held until the next render_start
//   vram_swap        pulse, flips the VRAM bank
//   cpu_swap_ack     four-phase acknowledge of cpu_swap_req
//   in_vblank        high while the scheduler is in VBLANK
//   overrun_count    saturating count of missed row deadlines
module ppu_row_sched (
  input  logic       video_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       vblank_start,
  input  logic       vblank_end_soon,
  input  logic       rowram_swap,
  input  logic       render_done,
  input  logic       cpu_swap_req,
  output logic       render_start,
  output logic [7:0] render_row,
  output logic       vram_swap,
  output logic       cpu_swap_ack,
  output logic       in_vblank,
  output logic [7:0] overrun_count
);

  localparam logic [7:0] LAST_ROW = 8'd239;

  typedef enum logic [1:0] {
    ST_VBLANK    = 2'd0,
    ST_WAIT      = 2'd1,
    ST_RENDER    = 2'd2,
    ST_FRAME_END = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] row_cnt_q, row_cnt_d;
  logic [7:0] render_row_q, render_row_d;
  logic [7:0] overrun_q, overrun_d;
  logic       render_start_q, render_start_d;
  logic       vram_swap_q, vram_swap_d;
  logic       ack_q, ack_d;
  logic       overrun_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Row scheduling: next state, row counter, render command and overruns.
  always_comb begin
    state_d        = state_q;
    row_cnt_d      = row_cnt_q;
    render_row_d   = render_row_q;
    render_start_d = 1'b0;
    overrun_hit    = 1'b0;

    if (vblank_start) begin
      // Blanking wins over everything; an unfinished frame is one overrun.
      state_d     = ST_VBLANK;
      overrun_hit = (state_q == ST_WAIT) || (state_q == ST_RENDER);
    end else begin
      case (state_q)
        ST_VBLANK: begin
          if (vblank_end_soon && enable) begin
            state_d        = ST_RENDER;
            row_cnt_d      = 8'd0;
            render_row_d   = 8'd0;
            render_start_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (rowram_swap) begin
            if (enable) begin
              state_d        = ST_RENDER;
              row_cnt_d      = row_cnt_q + 8'd1;
              render_row_d   = row_cnt_q + 8'd1;
              render_start_d = 1'b1;
            end else begin
              state_d = ST_FRAME_END;
            end
          end
        end
        ST_RENDER: begin
          if (render_done) begin
            // Done is taken before a coincident swap, so a same-cycle
            // swap is an ordinary on-time start of the next row.
            if ((row_cnt_q == LAST_ROW) || !enable) begin
              state_d = ST_FRAME_END;
            end else if (rowram_swap) begin
              row_cnt_d      = row_cnt_q + 8'd1;
              render_row_d   = row_cnt_q + 8'd1;
              render_start_d = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (rowram_swap) begin
            // Deadline missed: skip the row, keep rendering the late one.
            overrun_hit = 1'b1;
            if (row_cnt_q != LAST_ROW) begin
              row_cnt_d = row_cnt_q + 8'd1;
            end
          end
        end
        ST_FRAME_END: begin
          state_d = ST_FRAME_END;
        end
        default: begin
          state_d = ST_VBLANK;
        end
      endcase
    end

    overrun_d = overrun_hit ? sat_inc8(overrun_q) : overrun_q;
  end

  // Bank flip handshake. A flip is only granted in a VBLANK cycle that
  // also stays in VBLANK, so it can never coincide with render_start.
  always_comb begin
    vram_swap_d = 1'b0;
    ack_d       = ack_q;
    if (!ack_q) begin
      if (cpu_swap_req && (state_q == ST_VBLANK) && (state_d == ST_VBLANK)) begin
        vram_swap_d = 1'b1;
        ack_d       = 1'b1;
      end
    end else if (!cpu_swap_req) begin
      ack_d = 1'b0;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_VBLANK;
      row_cnt_q      <= 8'd0;
      render_row_q   <= 8'd0;
      render_start_q <= 1'b0;
      vram_swap_q    <= 1'b0;
      ack_q          <= 1'b0;
      overrun_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      render_row_q   <= render_row_d;
      render_start_q <= render_start_d;
      vram_swap_q    <= vram_swap_d;
      ack_q          <= ack_d;
      overrun_q      <= overrun_d;
    end
  end

  assign render_start  = render_start_q;
  assign render_row    = render_row_q;
  assign vram_swap     = vram_swap_q;
  assign cpu_swap_ack  = ack_q;
  assign in_vblank     = (state_q == ST_VBLANK);
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_ppu_row_sched.sv
module tb_ppu_row_sched;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       vblank_start;
  logic       vblank_end_soon;
  logic       rowram_swap;
  logic       render_done;
  logic       cpu_swap_req;
  logic       render_start;
  logic [7:0] render_row;
  logic       vram_swap;
  logic       cpu_swap_ack;
  logic       in_vblank;
  logic [7:0] overrun_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] rows_q[$];
  int start_cnt   = 0;
  int swap_cnt    = 0;
  int overlap_cnt = 0;

  ppu_row_sched dut (
    .video_clk      (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .vblank_start   (vblank_start),
    .vblank_end_soon(vblank_end_soon),
    .rowram_swap    (rowram_swap),
    .render_done    (render_done),
    .cpu_swap_req   (cpu_swap_req),
    .render_start   (render_start),
    .render_row     (render_row),
    .vram_swap      (vram_swap),
    .cpu_swap_ack   (cpu_swap_ack),
    .in_vblank      (in_vblank),
    .overrun_count  (overrun_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observe output pulses on the falling edge.
  always @(negedge clk) begin
    if (render_start === 1'b1) begin
      rows_q.push_back(render_row);
      start_cnt++;
    end
    if (vram_swap === 1'b1) swap_cnt++;
    if ((render_start === 1'b1) && (vram_swap === 1'b1)) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_done();
    render_done = 1'b1; tick(); render_done = 1'b0;
  endtask

  task automatic pulse_swap();
    rowram_swap = 1'b1; tick(); rowram_swap = 1'b0;
  endtask

  task automatic pulse_vbs();
    vblank_start = 1'b1; tick(); vblank_start = 1'b0;
  endtask

  task automatic start_frame();
    vblank_end_soon = 1'b1; tick(); vblank_end_soon = 1'b0;
    chk("frame_start_pulse", 32'(render_start), 32'd1);
    chk("frame_start_row", 32'(render_row), 32'd0);
  endtask

  // One on-time row: done well before the next buffer swap.
  task automatic do_row();
    repeat (2) tick();
    pulse_done();
    repeat (2) tick();
    pulse_swap();
  endtask

  initial begin
    int base;
    int sbase;
    int bad;

    rst_n = 1'b0; enable = 1'b1; vblank_start = 1'b0; vblank_end_soon = 1'b0;
    rowram_swap = 1'b0; render_done = 1'b0; cpu_swap_req = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_render_start", 32'(render_start), 32'd0);
    chk("rst_render_row", 32'(render_row), 32'd0);
    chk("rst_vram_swap", 32'(vram_swap), 32'd0);
    chk("rst_ack", 32'(cpu_swap_ack), 32'd0);
    chk("rst_overrun", 32'(overrun_count), 32'd0);
    chk("rst_in_vblank", 32'(in_vblank), 32'd1);
    rst_n = 1'b1;
    repeat (2) tick();

    // Nominal frame: 240 rows in order, then FRAME_END ignores the last swap
    base = rows_q.size();
    start_frame();
    chk("nom_left_vblank", 32'(in_vblank), 32'd0);
    for (int r = 0; r < 240; r++) do_row();
    tick();
    chk("nom_start_count", 32'(rows_q.size() - base), 32'd240);
    bad = 0;
    if (rows_q.size() >= base + 240) begin
      for (int i = 0; i < 240; i++) if (rows_q[base + i] !== 8'(i)) bad++;
    end else begin
      bad = 240;
    end
    chk("nom_row_order", 32'(bad), 32'd0);
    chk("nom_overrun", 32'(overrun_count), 32'd0);
    chk("nom_frame_end_not_vblank", 32'(in_vblank), 32'd0);
    pulse_done();
    pulse_swap();
    chk("nom_frame_end_no_start", 32'(rows_q.size() - base), 32'd240);
    pulse_vbs();
    chk("nom_vblank", 32'(in_vblank), 32'd1);
    chk("nom_vbs_no_overrun", 32'(overrun_count), 32'd0);

    // Overrun at row 5: row 6 skipped, next start is row 7
    base = rows_q.size();
    start_frame();
    for (int r = 0; r < 5; r++) do_row();
    chk("ovr_at_row5", 32'(render_row), 32'd5);
    repeat (2) tick();
    pulse_swap();
    chk("ovr_no_start", 32'(render_start), 32'd0);
    chk("ovr_count1", 32'(overrun_count), 32'd1);
    pulse_done();
    chk("ovr_still_active", 32'(in_vblank), 32'd0);
    pulse_swap();
    chk("ovr_next_start", 32'(render_start), 32'd1);
    chk("ovr_next_row", 32'(render_row), 32'd7);

    // Simultaneous done and swap at row 10
    for (int r = 0; r < 3; r++) do_row();
    chk("sim_at_row10", 32'(render_row), 32'd10);
    tick();
    render_done = 1'b1; rowram_swap = 1'b1;
    tick();
    render_done = 1'b0; rowram_swap = 1'b0;
    chk("sim_start", 32'(render_start), 32'd1);
    chk("sim_row", 32'(render_row), 32'd11);
    chk("sim_overrun_same", 32'(overrun_count), 32'd1);

    // Early vblank_start at row 100, late done ignored
    for (int r = 0; r < 89; r++) do_row();
    chk("early_at_row100", 32'(render_row), 32'd100);
    tick();
    pulse_vbs();
    chk("early_vblank", 32'(in_vblank), 32'd1);
    chk("early_overrun", 32'(overrun_count), 32'd2);
    pulse_done();
    chk("early_done_no_start", 32'(render_start), 32'd0);
    chk("early_done_stays_vblank", 32'(in_vblank), 32'd1);
    pulse_swap();
    chk("early_swap_ignored", 32'(overrun_count), 32'd2);
    tick();
    chk("early_start_count", 32'(rows_q.size() - base), 32'd100);
    if (rows_q.size() >= base + 7) chk("early_skip_row6", 32'(rows_q[base + 6]), 32'd7);

    // enable low: no frame start; dropping mid-frame ends the frame
    enable = 1'b0;
    vblank_end_soon = 1'b1; tick(); vblank_end_soon = 1'b0;
    chk("dis_no_start", 32'(render_start), 32'd0);
    chk("dis_stay_vblank", 32'(in_vblank), 32'd1);
    enable = 1'b1;
    start_frame();
    enable = 1'b0;
    repeat (2) tick();
    pulse_done();
    pulse_swap();
    chk("dis_mid_no_start", 32'(render_start), 32'd0);
    chk("dis_mid_overrun", 32'(overrun_count), 32'd2);
    pulse_vbs();
    chk("dis_frame_end_vbs", 32'(overrun_count), 32'd2);
    chk("dis_vblank", 32'(in_vblank), 32'd1);
    enable = 1'b1;

    // Swap handshake: request during WAIT waits for VBLANK
    start_frame();
    tick();
    pulse_done();
    sbase = swap_cnt;
    cpu_swap_req = 1'b1;
    repeat (5) tick();
    chk("hs_no_swap_in_wait", 32'(swap_cnt - sbase), 32'd0);
    chk("hs_no_ack_in_wait", 32'(cpu_swap_ack), 32'd0);
    pulse_vbs();
    chk("hs_vbs_overrun", 32'(overrun_count), 32'd3);
    chk("hs_swap_not_yet", 32'(vram_swap), 32'd0);
    tick();
    chk("hs_swap_pulse", 32'(vram_swap), 32'd1);
    chk("hs_ack_set", 32'(cpu_swap_ack), 32'd1);
    tick();
    chk("hs_swap_one_cycle", 32'(vram_swap), 32'd0);
    repeat (5) tick();
    chk("hs_single_swap", 32'(swap_cnt - sbase), 32'd1);
    chk("hs_ack_held", 32'(cpu_swap_ack), 32'd1);
    cpu_swap_req = 1'b0;
    tick();
    chk("hs_ack_clear", 32'(cpu_swap_ack), 32'd0);

    // Request and frame start in the same VBLANK cycle: render wins
    cpu_swap_req = 1'b1; vblank_end_soon = 1'b1;
    tick();
    vblank_end_soon = 1'b0;
    chk("col_start", 32'(render_start), 32'd1);
    chk("col_no_swap", 32'(vram_swap), 32'd0);
    tick();
    pulse_done();
    pulse_vbs();
    tick();
    chk("col_swap_later", 32'(vram_swap), 32'd1);
    cpu_swap_req = 1'b0;
    repeat (2) tick();
    chk("col_overlap", 32'(overlap_cnt), 32'd0);

    // Reset mid-render at row 50
    start_frame();
    for (int r = 0; r < 50; r++) do_row();
    chk("mrst_at_row50", 32'(render_row), 32'd50);
    rst_n = 1'b0;
    #1;
    chk("mrst_render_row", 32'(render_row), 32'd0);
    chk("mrst_render_start", 32'(render_start), 32'd0);
    chk("mrst_overrun", 32'(overrun_count), 32'd0);
    chk("mrst_in_vblank", 32'(in_vblank), 32'd1);
    chk("mrst_ack", 32'(cpu_swap_ack), 32'd0);
    chk("mrst_vram_swap", 32'(vram_swap), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_done();
    chk("mrst_done_ignored", 32'(render_start), 32'd0);
    chk("mrst_done_vblank", 32'(in_vblank), 32'd1);

    // 300 overruns saturate at 255; row counter caps at 239
    base = start_cnt;
    start_frame();
    repeat (300) pulse_swap();
    chk("sat_overrun", 32'(overrun_count), 32'd255);
    chk("sat_still_render", 32'(in_vblank), 32'd0);
    pulse_done();
    pulse_swap();
    tick();
    chk("sat_cap_frame_end", 32'(start_cnt - base), 32'd1);
    chk("sat_not_vblank", 32'(in_vblank), 32'd0);
    pulse_vbs();
    chk("sat_hold", 32'(overrun_count), 32'd255);
    chk("sat_vblank", 32'(in_vblank), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
